// File: rtl/uart_pkg.sv
// Shared UART definitions: line state encoding, bit-clock derivation and frame sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned DEF_DATA_BITS  = 8;
  localparam int unsigned DEF_PARITY_EN  = 1;
  localparam int unsigned DEF_STOP_BITS  = 1;
  localparam int unsigned DEF_FRAME_BITS = 1 + DEF_DATA_BITS + DEF_PARITY_EN + DEF_STOP_BITS;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned bit_clk(input int unsigned clk_hz, input int unsigned bps);
    return (clk_hz + bps / 2) / bps;
  endfunction

  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

  function automatic int unsigned frame_cycles(input int unsigned data_bits,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits,
                                               input int unsigned bit_clks);
    return frame_bits(data_bits, parity_en, stop_bits) * bit_clks;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last cycle of each BIT_CLK-cycle bit,
// pre_tick the cycle before it so registered outputs can line up with the tick.
module uart_baud_gen #(
  parameter int unsigned BIT_CLK = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CLK - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(BIT_CLK - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = enable && !clear && (cnt_q == LAST);
  assign pre_tick = enable && !clear && (cnt_q == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s);
// one frame in flight, host side is a valid/ready handshake.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 66_000_000,
  parameter int unsigned BITRATE_BPS = 9_600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_EN   = 1,
  parameter int unsigned PARITY_ODD  = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned BIT_CLK = bit_clk(CLK_HZ, BITRATE_BPS);
  localparam int unsigned BC_W    = 3;

  logic [1:0]           rst_sync_q;
  logic                 rst_int_n;
  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 accept;
  logic                 bit_tick;
  logic                 pre_tick;

  // Asynchronous assert, synchronous release of the internal reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];
  assign tx_ready  = (state_q == IDLE);
  assign accept    = tx_valid && tx_ready;

  uart_baud_gen #(
    .BIT_CLK (BIT_CLK)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .clear    (accept),
    .enable   (state_q != IDLE),
    .bit_tick (bit_tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    parity_d     = parity_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = tx_data;
          parity_d  = (^tx_data) ^ 1'(PARITY_ODD);
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        // Registered pulse must be launched one cycle ahead of the final tick.
        if (pre_tick && (bit_cnt_q == BC_W'(STOP_BITS - 1))) begin
          frame_done_d = 1'b1;
        end
        if (bit_tick) begin
          if (bit_cnt_q == BC_W'(STOP_BITS - 1)) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four frame configurations at BIT_CLK=10 checked every cycle
// against a frame-level line model, plus hand-computed frame and timing values.
module tb_uart_tx;

  localparam int BC = 10;

  logic       clk = 1'b0;
  logic       rstn [4] = '{default: 1'b0};
  logic       tv   [4] = '{default: 1'b0};
  logic [7:0] td   [4] = '{default: 8'h00};
  logic       tx_w [4];
  logic       rdy_w[4];
  logic       bsy_w[4];
  logic       fd_w [4];

  int         el   [4] = '{default: -1};
  logic [7:0] md   [4] = '{default: 8'h00};
  int         fd_cnt[4] = '{default: 0};
  int         vecs = 0;
  int         errs = 0;

  logic [10:0] lv_a5 = 11'b10101001010;
  logic [10:0] lv_7f = 11'b11111111110;

  always #5 clk = ~clk;

  uart_tx #(.CLK_HZ(1_000_000), .BITRATE_BPS(100_000), .DATA_BITS(8), .PARITY_EN(1),
            .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rstn[0]), .tx_data(td[0]), .tx_valid(tv[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(bsy_w[0]), .frame_done(fd_w[0]));

  uart_tx #(.CLK_HZ(1_000_000), .BITRATE_BPS(100_000), .DATA_BITS(8), .PARITY_EN(1),
            .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rstn[1]), .tx_data(td[1]), .tx_valid(tv[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(bsy_w[1]), .frame_done(fd_w[1]));

  uart_tx #(.CLK_HZ(1_000_000), .BITRATE_BPS(100_000), .DATA_BITS(8), .PARITY_EN(0),
            .PARITY_ODD(0), .STOP_BITS(1)) u_nopar (
    .clk(clk), .rst_n(rstn[2]), .tx_data(td[2]), .tx_valid(tv[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(bsy_w[2]), .frame_done(fd_w[2]));

  uart_tx #(.CLK_HZ(1_000_000), .BITRATE_BPS(100_000), .DATA_BITS(7), .PARITY_EN(1),
            .PARITY_ODD(0), .STOP_BITS(2)) u_d7s2 (
    .clk(clk), .rst_n(rstn[3]), .tx_data(td[3][6:0]), .tx_valid(tv[3]),
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(bsy_w[3]), .frame_done(fd_w[3]));

  function automatic int db(input int i);   return (i == 3) ? 7 : 8; endfunction
  function automatic int pe(input int i);   return (i == 2) ? 0 : 1; endfunction
  function automatic int po(input int i);   return (i == 1) ? 1 : 0; endfunction
  function automatic int sb(input int i);   return (i == 3) ? 2 : 1; endfunction
  function automatic int flen(input int i); return (1 + db(i) + pe(i) + sb(i)) * BC; endfunction

  function automatic logic par(input int i);
    logic p;
    p = (po(i) != 0);
    for (int k = 0; k < db(i); k++) p = p ^ md[i][k];
    return p;
  endfunction

  // Line level the frame demands at elapsed cycle el[i] since the accept edge.
  function automatic logic exp_tx(input int i);
    int b;
    b = el[i] / BC;
    if (b == 0) return 1'b0;
    if (b <= db(i)) return md[i][b-1];
    if (pe(i) != 0 && b == db(i) + 1) return par(i);
    return 1'b1;
  endfunction

  // Frame model: a frame is taken only when the model is idle, and lasts flen cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rstn[i]) el[i] = -1;
      else if (el[i] < 0) begin
        if (tv[i]) begin
          el[i] = 0;
          md[i] = td[i];
        end
      end else if (el[i] == flen(i) - 1) el[i] = -1;
      else el[i] = el[i] + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      if (errs <= 30) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    int b;
    for (int i = 0; i < 4; i++) begin
      if (fd_w[i] === 1'b1) fd_cnt[i]++;
      if (!rstn[i] || el[i] < 0) begin
        chk($sformatf("idle_tx[%0d]", i),    32'(tx_w[i]),  32'd1);
        chk($sformatf("idle_busy[%0d]", i),  32'(bsy_w[i]), 32'd0);
        chk($sformatf("idle_ready[%0d]", i), 32'(rdy_w[i]), 32'd1);
        chk($sformatf("idle_fd[%0d]", i),    32'(fd_w[i]),  32'd0);
      end else begin
        chk($sformatf("tx[%0d]@%0d", i, el[i]),    32'(tx_w[i]),  32'(exp_tx(i)));
        chk($sformatf("busy[%0d]@%0d", i, el[i]),  32'(bsy_w[i]), 32'd1);
        chk($sformatf("ready[%0d]@%0d", i, el[i]), 32'(rdy_w[i]), 32'd0);
        chk($sformatf("fd[%0d]@%0d", i, el[i]),    32'(fd_w[i]),  32'(el[i] == flen(i) - 1));
        if (el[i] % BC == 5) begin
          b = el[i] / BC;
          if (i == 0 && md[0] == 8'hA5) chk($sformatf("a5_bit%0d", b), 32'(tx_w[0]), 32'(lv_a5[b]));
          if (i == 3 && md[3][6:0] == 7'h7F) chk($sformatf("d7_7f_bit%0d", b), 32'(tx_w[3]), 32'(lv_7f[b]));
          if (i == 1 && md[1] == 8'h07 && b == 9) chk("odd_parity_07", 32'(tx_w[1]), 32'd0);
        end
      end
    end
  endtask

  // Offer one byte, then count cycles from the accept edge to the frame_done pulse.
  task automatic send_meas(input int i, input logic [7:0] d, input int exp_len, input string name);
    int n;
    @(negedge clk);
    td[i] = d;
    tv[i] = 1'b1;
    @(negedge clk);
    tv[i] = 1'b0;
    td[i] = ~d;
    n = 1;
    while (fd_w[i] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n), 32'(exp_len));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      begin : stim
        int n, g, base;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) rstn[i] = 1'b1;
        repeat (200) @(negedge clk);
        chk("idle_no_frame_done", 32'(fd_cnt[0] + fd_cnt[1] + fd_cnt[2] + fd_cnt[3]), 32'd0);

        send_meas(0, 8'hA5, 110, "len_a5_even");
        send_meas(1, 8'h07, 110, "len_07_odd");
        send_meas(2, 8'h07, 100, "len_07_nopar");
        send_meas(3, 8'h7F, 110, "len_7f_d7s2");

        // Back-to-back with tx_valid held high, plus valid pulses while busy.
        base = fd_cnt[0];
        @(negedge clk);
        td[0] = 8'h55;
        tv[0] = 1'b1;
        @(negedge clk);
        td[0] = 8'hFF;
        n = 1;
        while (fd_w[0] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        chk("b2b_len1", 32'(n), 32'd110);
        g = 0;
        while (tx_w[0] !== 1'b0 && g < 10) begin @(negedge clk); g++; end
        chk("b2b_gap", 32'(g), 32'd2);
        n = 1;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          n++;
          tv[0] = ~tv[0];
          td[0] = 8'(k);
        end
        tv[0] = 1'b0;
        while (fd_w[0] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        chk("b2b_len2", 32'(n), 32'd110);
        repeat (20) @(negedge clk);
        chk("b2b_frame_count", 32'(fd_cnt[0] - base), 32'd2);

        // Reset mid-frame: line must return high without waiting for a clock.
        @(negedge clk);
        td[0] = 8'h00;
        tv[0] = 1'b1;
        @(negedge clk);
        tv[0] = 1'b0;
        repeat (45) @(negedge clk);
        chk("pre_reset_tx", 32'(tx_w[0]), 32'd0);
        #2 rstn[0] = 1'b0;
        #1;
        chk("async_reset_tx", 32'(tx_w[0]), 32'd1);
        chk("async_reset_busy", 32'(bsy_w[0]), 32'd0);
        chk("async_reset_ready", 32'(rdy_w[0]), 32'd1);
        repeat (3) @(negedge clk);
        rstn[0] = 1'b1;
        repeat (4) @(negedge clk);
        base = fd_cnt[0];
        send_meas(0, 8'h3C, 110, "len_after_reset");
        repeat (5) @(negedge clk);
        chk("after_reset_one_frame", 32'(fd_cnt[0] - base), 32'd1);
      end
      begin : watchdog
        repeat (20000) @(posedge clk);
        vecs++;
        errs++;
        $display("FAIL watchdog: stimulus still running after %0d cycles, expected completion", 20000);
      end
      forever begin
        @(negedge clk);
        cmp_all();
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
